// File: rtl/regfile_write_bank.sv
// regfile_write_bank: 32-register write bank with handshake writes and clear sweep; REGFILE_BYTE_WRITE_EN enables byte writes
module regfile_write_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              din,
  input  logic [DATA_W/8-1:0]            ben,
  input  logic                           clr_req,
  output logic                           clr_busy,
  output logic [(2**ADDR_W)*DATA_W-1:0]  regs_flat,
  output logic [CNT_W-1:0]               wr_cnt
);
  localparam int NREGS = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wmask;
  assign wr_ready = state == IDLE && !clr_req;
  assign clr_busy = state == CLEAR;
`ifdef REGFILE_BYTE_WRITE_EN
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_mask
    assign wmask[8*b +: 8] = {8{ben[b]}};
  end
`else
  logic unused_ben;
  assign unused_ben = ^ben;
  assign wmask = '1;
`endif
  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = regs[k];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wr_cnt <= '0;
      state <= IDLE;
      clr_ptr <= ADDR_W'(1);
    end else if (state == IDLE) begin
      if (clr_req) begin
        state <= CLEAR;
        clr_ptr <= ADDR_W'(1);
      end else if (wr_valid && waddr != '0) begin
        regs[waddr] <= (regs[waddr] & ~wmask) | (din & wmask);
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end else begin
      regs[clr_ptr] <= '0;
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == '1) state <= IDLE;
    end
  end
endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the MIPS general-purpose register file: storage for 32 registers plus the 5-to-32 write decoder.
- Accepts write-back requests over a valid/ready handshake and supports a sequential register-clear sweep.
- All register contents are exposed as one flat bus that feeds the 32:1 read-port multiplexers.
- Sits between the write-back stage and the register-file read ports.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
- CNT_W, 16, width of the accepted-write counter.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset
- Wr_valid  input  1  write request valid
- Wr_ready  output  1  write request can be accepted this cycle
- Waddr  input  ADDR_W  destination register number
- Din  input  DATA_W  write data
- Ben  input  DATA_W/8  byte enables; bit i covers Din[8i+7:8i]
- Clr_req  input  1  request clear sweep of registers 1..NREGS-1
- Clr_busy  output  1  clear sweep in progress
- Regs_flat  output  NREGS*DATA_W  register k on bits [k*DATA_W+DATA_W-1 : k*DATA_W]
- Wr_cnt  output  CNT_W  number of committed writes to nonzero registers

Behaviour:
- One clock, Clk. Reset is synchronous and active-low on Rst_n: sampled only on the rising edge of Clk.
- Reset (Rst_n=0 at an edge):
  - all registers <= 0, Wr_cnt <= 0, state <= IDLE, clear pointer <= 1.
  - Outputs after reset: Regs_flat=0, Wr_cnt=0, Clr_busy=0, Wr_ready=1 while Clr_req=0.
- States:
  - IDLE: accepts writes.
  - CLEAR: sweeps one register per cycle.
- Combinational outputs:
  - Wr_ready = (state==IDLE) && !Clr_req.
  - Clr_busy = (state==CLEAR).
- Write acceptance:
  - A write is accepted on an edge where Wr_valid && Wr_ready.
  - The target register is updated at that same edge and is visible on Regs_flat the following cycle (latency 1).
  - There is no internal buffering; Wr_valid with Wr_ready=0 is not accepted, and the source must hold Waddr/Din/Ben stable until it is.
- Register 0:
  - Always reads 0.
  - Accepted writes with Waddr==0 complete the handshake but modify nothing and do not increment Wr_cnt.
- Wr_cnt:
  - Increments by 1 per accepted write with Waddr!=0.
  - Wraps from 2**CNT_W-1 to 0.
  - Increments even when Ben==0 (when byte writes are enabled).
- IDLE -> CLEAR:
  - Happens on an edge with Clr_req=1.
  - Clr_req has priority over Wr_valid in the same cycle; the write is not accepted because Wr_ready=0.
  - Clear pointer loads 1.
- CLEAR:
  - Each edge zeroes the register at the clear pointer, then increments the pointer.
  - The edge that zeroes register NREGS-1 returns the state to IDLE.
  - The sweep is exactly NREGS-1 cycles (31 by default).
  - Clr_req is ignored while in CLEAR; a Clr_req still high on return to IDLE starts a new sweep.
  - No writes are accepted during CLEAR.
  - Wr_cnt is unchanged by clearing.
- Reset during CLEAR: aborts the sweep; all registers and state return to reset values.
- Registers not addressed by a write or by the clear pointer hold their value.

Optional Feature:
- Macro: REGFILE_BYTE_WRITE_EN.
- Defined: each accepted write updates only the bytes whose Ben bit is 1; other bytes of the target register hold their value.
- Undefined: Ben is ignored and every accepted write replaces the full DATA_W word.
- The port list is identical in both builds.

Test Plan:
- Reset with Rst_n=0 for 2 cycles, then release -> Regs_flat=0, Wr_cnt=0, Wr_ready=1, Clr_busy=0.
- Write Waddr=5, Din=0xDEADBEEF, Ben=0xF, then Waddr=0, Din=0x12345678 -> next cycle register 5=0xDEADBEEF; register 0 stays 0; Wr_cnt=1; both handshakes complete.
- With REGFILE_BYTE_WRITE_EN: write register 7=0x11223344, then Din=0xAABBCCDD, Ben=0x5 -> register 7=0x11BB33DD.
  - Without the macro, the same sequence gives register 7=0xAABBCCDD.
- Load registers 1..31 with k*0x01010101, then pulse Clr_req with Wr_valid=1 in the same cycle:
  - the write is not accepted;
  - Clr_busy=1 for exactly 31 cycles, during which Wr_ready=0;
  - afterwards all registers are 0 and Wr_cnt=31.
- Start a clear sweep, assert Rst_n=0 on sweep cycle 10 -> next cycle state IDLE, Clr_busy=0, all registers 0, Wr_cnt=0.
- Build with CNT_W=4 and perform 17 writes to register 3 -> Wr_cnt=1 (wrap from 15 to 0 observed at write 16).
